// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
//   mem_req   : request, held high for the whole bus transaction
//   mem_we    : write enable (store)
//   mem_addr  : word-aligned address
//   mem_be    : byte-lane enables, lane k = bits 8k+7:8k
//   mem_wdata : lane-replicated store data
//   mem_ack   : acknowledge from memory, ends the transaction
//   mem_rdata : read data, valid with mem_ack
// master: the load/store unit.  slave: the memory.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store engine of the MEM stage. Accepts one decoded load/store, runs a
// single transaction on the data-memory bus and returns extended load data
// for the GPR write-back mux.
//   clk, reset : clock, synchronous active-high reset
//   start      : request from MEM stage (only looked at while idle)
//   op         : {store, unsigned, size[1:0]}; size 00 byte, 01 half, 10 word
//   addr       : byte address
//   wdata      : store data, low bytes significant
//   busy       : pipeline stall request
//   done       : one-cycle completion pulse
//   err        : 00 ok, 01 misaligned/illegal, 10 timeout (valid with done)
//   rdata      : extended load data, held until the next successful load
//   bus        : data-memory bus (master side)
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   tcnt_p1;
  logic               we_p1;
  logic               uns_p1;
  logic [1:0]         size_p1;
  logic [1:0]         lane_p1;
  logic [31:0]        addr_p1;
  logic [31:0]        wdata_p1;
  logic [3:0]         be_p1;
  logic [1:0]         err_p1;
  logic               misalign;
  logic               tmo_hit;

  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] lane);
    case (size)
      2'b00:   lane_enables = 4'b0001 << lane;
      2'b01:   lane_enables = 4'b0011 << lane;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0]  size,
                                                 input logic [31:0] d);
    case (size)
      2'b00:   lane_replicate = {4{d[7:0]}};
      2'b01:   lane_replicate = {2{d[15:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] d,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'd0, b} : 32'(b);
      2'b01:   load_extend = uns ? {16'd0, h} : 32'(h);
      default: load_extend = d;
    endcase
  endfunction

  always_comb begin
    case (op[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // The counter holds the number of ack-less BUS cycles already completed,
  // so hitting TIMEOUT-1 here means this is the TIMEOUT-th BUS cycle.
  assign tmo_hit = (tcnt_p1 == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        busy = start;
        if (start) state_n = misalign ? RESP : BUS;
      end
      BUS: begin
        busy = 1'b1;
        if (bus.mem_ack || tmo_hit) state_n = RESP;
      end
      RESP: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture (IDLE) and completion capture (BUS)
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_p1  <= '0;
      we_p1    <= 1'b0;
      uns_p1   <= 1'b0;
      size_p1  <= 2'b00;
      lane_p1  <= 2'b00;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      be_p1    <= '0;
      err_p1   <= 2'b00;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt_p1 <= '0;
          if (start) begin
            if (misalign) begin
              err_p1 <= 2'b01;
            end else begin
              we_p1    <= op[3];
              uns_p1   <= op[2];
              size_p1  <= op[1:0];
              lane_p1  <= addr[1:0];
              addr_p1  <= {addr[31:2], 2'b00};
              be_p1    <= lane_enables(op[1:0], addr[1:0]);
              wdata_p1 <= lane_replicate(op[1:0], wdata);
            end
          end
        end
        BUS: begin
          if (bus.mem_ack) begin
            err_p1 <= 2'b00;
            if (!we_p1) rdata <= load_extend(bus.mem_rdata, size_p1, lane_p1, uns_p1);
          end else if (tmo_hit) begin
            err_p1 <= 2'b10;
          end else begin
            tcnt_p1 <= tcnt_p1 + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign err           = err_p1;
  assign bus.mem_req   = (state == BUS);
  assign bus.mem_we    = (state == BUS) & we_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_be    = be_p1;
  assign bus.mem_wdata = wdata_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int TIMEOUT = 16;
  localparam int NOACK   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata;

  mem_access_unit_if bus_if();

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          lat;
    int          reqs;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // memory responder configuration for the access in flight
  logic        cfg_bus;
  logic        cfg_we;
  logic [31:0] cfg_addr;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  int          cfg_waits;
  int          reqcnt;
  logic [31:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load: shift the addressed bytes down, mask to size, sign-fix.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] size, input logic uns);
    int     n;
    longint v;
    longint full;
    n    = 1 << size;
    full = 64'd1 << (8 * n);
    v    = longint'({32'd0, w} >> (8 * a)) & (full - 1);
    if (!uns && v >= full / 2) v = v - full;
    return 32'(v);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: checks bus outputs during requests, acks after cfg_waits wait
  // cycles, and sprays random ack/data outside requests.
  always @(negedge clk) begin
    if (bus_if.mem_req === 1'b1) begin
      reqcnt++;
      if (!cfg_bus) begin
        check("mem_req_unexpected", bus_if.mem_req, 1'b0);
      end else begin
        check("mem_addr", bus_if.mem_addr, cfg_addr);
        check("mem_be", bus_if.mem_be, cfg_be);
        check("mem_we", bus_if.mem_we, cfg_we);
        if (cfg_we) check("mem_wdata", bus_if.mem_wdata, cfg_wdata);
      end
      bus_if.mem_ack   = (reqcnt == cfg_waits + 1);
      bus_if.mem_rdata = bus_if.mem_ack ? cfg_rdata : $urandom;
    end else begin
      bus_if.mem_ack   = 1'($urandom_range(0, 1));
      bus_if.mem_rdata = $urandom;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("err", err, e.err);
        check("rdata", rdata, e.rdata);
        check("latency", cyc - e.t0, e.lat);
        check("req_cycles", reqcnt, e.reqs);
        check("busy_on_done", busy, 1'b0);
      end
    end
  end

  task automatic access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] memword);
    exp_t e;
    int   n;
    int   sh;
    int   k;
    logic bad;
    n   = 1 << o[1:0];
    sh  = int'(a[1:0]);
    bad = (o[1:0] == 2'b11) || (sh % n != 0);
    cfg_bus   = !bad;
    cfg_we    = o[3];
    cfg_addr  = a & 32'hffff_fffc;
    cfg_be    = '0;
    cfg_wdata = '0;
    if (!bad) begin
      for (int i = 0; i < n; i++) cfg_be[sh + i] = 1'b1;
      for (int l = 0; l < 4; l++) cfg_wdata[8*l +: 8] = wd[8*(l % n) +: 8];
    end
    cfg_waits = waits;
    cfg_rdata = memword;
    reqcnt    = 0;
    if (bad) begin
      e.err = 2'b01; e.lat = 1; e.reqs = 0;
    end else if (waits >= TIMEOUT) begin
      e.err = 2'b10; e.lat = TIMEOUT + 1; e.reqs = TIMEOUT;
    end else begin
      e.err = 2'b00; e.lat = 2 + waits; e.reqs = waits + 1;
      if (!o[3]) model_rdata = ref_load(memword, a[1:0], o[1:0], o[2]);
    end
    e.rdata = model_rdata;
    e.t0    = cyc;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    addr  = a;
    wdata = wd;
    @(negedge clk);
    check("busy_issue", busy, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 3 * TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done expected done within %0d cycles", 3 * TIMEOUT);
      sb.delete();
    end
    // start stays high through the done cycle, as the stage only advances then
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 4'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  task automatic reset_in_bus();
    cfg_bus   = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 32'h0000_0300;
    cfg_be    = 4'b1111;
    cfg_rdata = 32'h1111_2222;
    cfg_waits = 5;
    reqcnt    = 0;
    start = 1'b1;
    op    = 4'b0010;
    addr  = 32'h0000_0300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_bus_req_still", bus_if.mem_req, 1'b1);
    @(negedge clk);
    check("rst_mem_req", bus_if.mem_req, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_be", bus_if.mem_be, 4'd0);
    model_rdata = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", done, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] a;
    int          w;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    addr  = '0;
    wdata = '0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = '0;
    cfg_bus = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_be = '0;
    cfg_wdata = '0; cfg_rdata = '0; cfg_waits = NOACK; reqcnt = 0;
    model_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 2'b00);
    check("reset_rdata", rdata, 32'd0);
    check("reset_mem_req", bus_if.mem_req, 1'b0);
    check("reset_mem_we", bus_if.mem_we, 1'b0);
    check("reset_mem_addr", bus_if.mem_addr, 32'd0);
    check("reset_mem_be", bus_if.mem_be, 4'd0);
    check("reset_mem_wdata", bus_if.mem_wdata, 32'd0);
    @(posedge clk); #1;

    access(4'b0010, 32'h0000_0100, 32'h0, 0, 32'hdeadbeef);
    access(4'b0000, 32'h0000_0103, 32'h0, 2, 32'h80c0ffee);
    access(4'b0100, 32'h0000_0103, 32'h0, 2, 32'h80c0ffee);
    access(4'b1001, 32'h0000_0202, 32'h1234c0de, 0, 32'h5555_aaaa);
    access(4'b0010, 32'h0000_0101, 32'h0, 0, 32'h0bad_0bad);
    access(4'b0011, 32'h0000_0100, 32'h0, 0, 32'h0bad_0bad);
    access(4'b0010, 32'h0000_0400, 32'h0, NOACK, 32'h0bad_0bad);
    access(4'b0010, 32'h0000_0404, 32'h0, 0, 32'h7654_3210);
    access(4'b0001, 32'h0000_0406, 32'h0, TIMEOUT - 1, 32'h9abc_1234);
    access(4'b1010, 32'h0000_0408, 32'hcafe_f00d, 1, 32'h0);
    access(4'b1000, 32'h0000_0409, 32'h0000_00a5, 0, 32'h0);
    reset_in_bus();
    access(4'b0110, 32'h0000_0500, 32'h0, 0, 32'hfedc_8765);

    for (int t = 0; t < 60; t++) begin
      o = 4'($urandom);
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (o[1:0] == 2'b10) ? 2'b00 : (o[1:0] == 2'b01 ? {a[1], 1'b0} : a[1:0]);
      case ($urandom_range(0, 9))
        0:       w = NOACK;
        1:       w = TIMEOUT - 1;
        default: w = $urandom_range(0, 3);
      endcase
      access(o, a, $urandom, w, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store engine of the MEM stage: takes a decoded load/store from the pipeline, runs one transaction on the data-memory request/acknowledge bus with byte-lane enables, and returns sign/zero-extended load data. Its `rdata` output is the memory-source operand for the GPR write-back mux (`GPR_WRITE_MEM` path). It stalls the pipeline via `busy` until the access completes, and flags misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT, 16: maximum BUS-state cycles without `mem_ack` before abort (≥1)
- clk  in  1  clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- start  in  1  request from MEM stage; sampled only in IDLE
- op  in  4  {store, unsigned, size[1:0]}; size 00 byte, 01 half, 10 word, 11 illegal; unsigned ignored for stores
- addr  in  32  byte address
- wdata  in  32  store data (low bytes significant)
- busy  out  1  stall request to pipeline
- done  out  1  one-cycle completion pulse
- err  out  2  valid with done: 00 ok, 01 misaligned/illegal, 10 timeout
- rdata  out  32  extended load data, held until next successful load
- mem_req, mem_we  out  1  bus request / write enable
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables, lane k = bits 8k+7:8k
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus acknowledge
- mem_rdata  in  32  bus read data, valid with mem_ack

## Operation
- Little-endian lanes: byte at addr[1:0]=k on lane k.
- States IDLE, BUS, RESP.
- IDLE, start=1, legal aligned op: register op, addr, be, wdata; go BUS.
- IDLE, start=1, misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size=11: no bus cycle; go RESP with err=01.
- BUS: mem_req=1, all mem_* outputs stable from registers. On mem_ack=1: loads capture extended lane data into rdata; go RESP, err=00. Timeout counter increments each BUS cycle without ack; on reaching TIMEOUT, go RESP with err=10, rdata unchanged.
- RESP: done=1 for exactly one cycle, err valid; always return to IDLE. start in RESP is ignored (same instruction still presented).
- be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extension: byte lane selected by addr[1:0], half by addr[1]; sign-extend when unsigned=0, else zero-extend.
- Stores and errored accesses never modify rdata.
- mem_ack outside BUS is ignored.

## Timing
- Reset: state IDLE, busy/done/mem_req/mem_we 0, err 00, rdata 0, mem_addr/mem_be/mem_wdata 0, timeout counter 0.
- busy = (state==BUS) | (state==IDLE & start); low in RESP so the stage advances on the done cycle.
- Zero-wait access: start at cycle 0, mem_req at cycle 1, ack at cycle 1, done + valid rdata at cycle 2. Each wait cycle adds one.
- Error path: start at cycle 0, done with err=01 at cycle 1, mem_req never asserted.
- Timeout: mem_req high for exactly TIMEOUT cycles, drops the cycle done/err=10 rises.
- Ack on the same cycle the counter reaches TIMEOUT: ack wins, err=00.
- Reset during BUS or RESP: mem_req and done low the next cycle, no completion reported.
- Minimum issue interval: one access per 3 cycles.

## Test plan
- LW addr 0x100, mem_rdata 0xdeadbeef, zero wait -> mem_be 1111, mem_addr 0x100, done at cycle 2, rdata 0xdeadbeef, err 00.
- LB addr 0x103 / LBU addr 0x103, mem_rdata 0x80c0ffee, 2 wait cycles -> rdata 0xffffff80 / 0x00000080, done at cycle 4.
- SH addr 0x202, wdata 0x1234c0de -> mem_we 1, mem_be 1100, mem_wdata 0xc0dec0de, mem_addr 0x200, rdata unchanged.
- LW addr 0x101 and op size 11 -> done cycle 1, err 01, mem_req never high.
- Never acknowledge, TIMEOUT=16 -> mem_req high 16 cycles, done with err 10; then LW succeeds normally.
- Reset asserted in second BUS cycle -> mem_req 0 next cycle, no done; start held through RESP does not issue a second transaction.
